dual_issue_scheduler: RTL and testbench
=======================================

# dual_issue_scheduler

- Sits between the fetch pair buffer and the two execute pipes of the superscalar core.
- Each cycle it accepts an instruction pair (slot A = older, slot B = younger) with a valid/ready handshake and decodes opcode, rd, rs1 and rs2 using the standard RV32 field positions.
- It issues both instructions together when legal. Otherwise it issues A alone and holds B for the following cycle.
- It also keeps dual-issue and single-issue performance counters.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch pair present.
- in_b_valid  in  1  slot B of the pair is valid; ignored when in_valid=0.
- in_instr_a, in_instr_b  in  32 each  instruction words.
- in_pc  in  32  PC of slot A; slot B PC is in_pc+4.
- in_ready  out  1  scheduler accepts a pair this cycle.
- issue_ready  in  1  backend can take issued instructions this cycle.
- flush  in  1  mispredict/redirect: discard all buffered instructions.
- issue0_valid, issue0_instr (32), issue0_pc (32)  out  older issued instruction.
- issue1_valid, issue1_instr (32), issue1_pc (32)  out  younger issued instruction.
- dual_cnt, single_cnt  out  CNT_W  issue-event counters, wrapping.

## Operation
Opcodes and register use:
- LOAD 0000011: writes rd, reads rs1, memory op.
- S_TYPE 0100011: reads rs1 and rs2, memory op.
- JAL 1101111: writes rd, control op.
- B_TYPE 1100011: reads rs1 and rs2, control op.
- I_IMME 0010011: writes rd, reads rs1.
- R_TYPE 0110011: writes rd, reads rs1 and rs2.
- Any other opcode: no reads, no writes, not memory, not control; it is issued normally.
- A write to rd=x0 counts as no write.

Pair conflict (conflict=1) when any of the following holds:
- RAW: A writes rd and B reads rs1 or rs2 equal to that rd.
- WAW: A and B both write the same nonzero rd.
- Structural: A and B are both memory ops (single memory port).
- A is a control op.

Internal buffer: buf_a, buf_b, buf_pc plus a state register.
- EMPTY: no instructions held.
- PAIR: A held; B held if buf_b_v=1.
- HOLD_B: only the younger instruction is held; it was left over from a conflicting pair.

Issue outputs are combinational from the buffer:
- PAIR, no conflict, buf_b_v=1: issue0=A at buf_pc, issue1=B at buf_pc+4.
- PAIR with conflict, or buf_b_v=0: issue0=A, issue1_valid=0.
- HOLD_B: issue0=B at buf_pc+4, issue1_valid=0.
- EMPTY: both valids are 0. Data outputs are don't-care but must be driven with the buffer contents (no X).

Transitions, taken only when issue_ready=1 and flush=0:
- PAIR issuing both, or PAIR with no B: go to PAIR if a pair is accepted this cycle, else EMPTY.
- PAIR with conflict: go to HOLD_B.
- HOLD_B: go to PAIR if a pair is accepted this cycle, else EMPTY.
- EMPTY: go to PAIR if a pair is accepted.
- issue_ready=0: state and buffer hold; only EMPTY can accept a pair.

in_ready:
- in_ready = !reset & !flush & (EMPTY | (issue_ready & the buffer drains this cycle)).
- The path from issue_ready to in_ready is combinational.
- A pair is accepted when in_valid & in_ready.

flush:
- Synchronous. Next state is EMPTY, and any pair offered in the same cycle is not accepted (in_ready=0).
- Issue outputs in a flush cycle still show the buffer. The backend ignores them under flush, and the counters do not count them.

Counters, only when issue_ready=1, flush=0 and the buffer is non-empty:
- dual_cnt += 1 when both slots issue.
- single_cnt += 1 when exactly one slot issues.
- Both wrap at 2^CNT_W.

## Timing
- A pair accepted at edge N is visible on the issue outputs in the cycle after edge N; minimum latency is 1 cycle.
- Sustained throughput with no conflicts and issue_ready=1 is one pair per cycle.
- A conflicting pair takes 2 cycles and inserts one in_ready=0 cycle.
- Reset (asynchronous, immediate):
  - state EMPTY; all buffer registers 0.
  - issue0_valid = issue1_valid = 0; all data outputs 0.
  - dual_cnt = single_cnt = 0; in_ready = 0 while reset is high.
- Reset asserted mid-HOLD_B or mid-PAIR discards the held instructions; no issue valid goes high until a new pair is accepted.
- flush and issue_ready=0 together: flush wins.

## Test plan
- Independent pair: in_instr_a=0x00500093 (addi x1,x0,5), in_instr_b=0x00700193 (addi x3,x0,7), pc=0x100.
  -> Next cycle both valids=1, issue0_pc=0x100, issue1_pc=0x104; dual_cnt=1.
- RAW pair: in_instr_a=0x00500093, in_instr_b=0x00108133 (add x2,x1,x1).
  -> Cycle 1: issue0 only, showing A.
  -> Cycle 2: issue0=0x00108133 at pc+4, in_ready=1.
  -> single_cnt=2.
- Dual load: in_instr_a=0x0000A283, in_instr_b=0x00412303.
  -> Issued serially in two cycles; in_ready=0 during the first.
- Control in A: in_instr_a=0x000000EF (jal x1), in_instr_b=0x00700193.
  -> JAL issues alone; B follows the next cycle.
  -> Same pair with rd=x0 write in A still serializes, because JAL is a control op.
- Backpressure and flush:
  - Hold issue_ready=0 for 3 cycles. -> Outputs stable, in_ready=0, counters unchanged.
  - Assert flush while in HOLD_B. -> Next cycle both valids=0, state EMPTY; the pair offered in the flush cycle is not accepted.
- Async reset mid-PAIR. -> Outputs go to 0 immediately, without waiting for a clock edge; counters read 0.

Source files
------------

// File: rtl/dual_issue_scheduler_if.sv
// rtl/dual_issue_scheduler_if.sv - fetch-pair input, issue outputs and counters of the dual-issue scheduler
interface dual_issue_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_b_valid;
    logic [31:0]      in_instr_a;
    logic [31:0]      in_instr_b;
    logic [31:0]      in_pc;
    logic             in_ready;
    logic             issue_ready;
    logic             flush;
    logic             issue0_valid;
    logic [31:0]      issue0_instr;
    logic [31:0]      issue0_pc;
    logic             issue1_valid;
    logic [31:0]      issue1_instr;
    logic [31:0]      issue1_pc;
    logic [CNT_W-1:0] dual_cnt;
    logic [CNT_W-1:0] single_cnt;

    // Fetch/backend side driving the scheduler
    modport master (
        output in_valid, in_b_valid, in_instr_a, in_instr_b, in_pc,
        output issue_ready, flush,
        input  in_ready,
        input  issue0_valid, issue0_instr, issue0_pc,
        input  issue1_valid, issue1_instr, issue1_pc,
        input  dual_cnt, single_cnt
    );

    // Scheduler side
    modport slave (
        input  in_valid, in_b_valid, in_instr_a, in_instr_b, in_pc,
        input  issue_ready, flush,
        output in_ready,
        output issue0_valid, issue0_instr, issue0_pc,
        output issue1_valid, issue1_instr, issue1_pc,
        output dual_cnt, single_cnt
    );
endinterface

// File: rtl/dual_issue_scheduler.sv
// rtl/dual_issue_scheduler.sv - buffers a fetch pair and issues it dual or split across two cycles
module dual_issue_scheduler #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    dual_issue_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_PAIR   = 2'd1,
        ST_HOLD_B = 2'd2
    } state_t;

    typedef struct packed {
        logic wr;
        logic rd_rs1;
        logic rd_rs2;
        logic mem;
        logic ctrl;
    } dec_t;

    // Register usage and op class from the opcode; a write to x0 is no write
    function automatic dec_t decode(input logic [6:0] op, input logic [4:0] rd);
        dec_t d;
        d = '0;
        case (op)
            7'b0000011: begin d.wr = 1'b1; d.rd_rs1 = 1'b1; d.mem = 1'b1; end
            7'b0100011: begin d.rd_rs1 = 1'b1; d.rd_rs2 = 1'b1; d.mem = 1'b1; end
            7'b1101111: begin d.wr = 1'b1; d.ctrl = 1'b1; end
            7'b1100011: begin d.rd_rs1 = 1'b1; d.rd_rs2 = 1'b1; d.ctrl = 1'b1; end
            7'b0010011: begin d.wr = 1'b1; d.rd_rs1 = 1'b1; end
            7'b0110011: begin d.wr = 1'b1; d.rd_rs1 = 1'b1; d.rd_rs2 = 1'b1; end
            default:    d = '0;
        endcase
        if (rd == 5'd0) d.wr = 1'b0;
        return d;
    endfunction

    state_t           r_state;
    logic [31:0]      r_buf_a;
    logic [31:0]      r_buf_b;
    logic             r_buf_b_v;
    logic [31:0]      r_buf_pc;
    logic [CNT_W-1:0] r_dual_cnt;
    logic [CNT_W-1:0] r_single_cnt;

    dec_t        w_dec_a;
    dec_t        w_dec_b;
    logic        w_raw;
    logic        w_waw;
    logic        w_conflict;
    logic        w_dual;
    logic        w_drain;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_count_en;
    logic [31:0] w_pc_b;

    assign w_dec_a = decode(r_buf_a[6:0], r_buf_a[11:7]);
    assign w_dec_b = decode(r_buf_b[6:0], r_buf_b[11:7]);

    assign w_raw = w_dec_a.wr &
                   ((w_dec_b.rd_rs1 & (r_buf_b[19:15] == r_buf_a[11:7])) |
                    (w_dec_b.rd_rs2 & (r_buf_b[24:20] == r_buf_a[11:7])));
    assign w_waw = w_dec_a.wr & w_dec_b.wr & (r_buf_a[11:7] == r_buf_b[11:7]);

    // Only meaningful while a real B sits next to A
    assign w_conflict = r_buf_b_v & (w_raw | w_waw | (w_dec_a.mem & w_dec_b.mem) | w_dec_a.ctrl);

    assign w_dual  = (r_state == ST_PAIR) & r_buf_b_v & ~w_conflict;
    assign w_drain = ((r_state == ST_PAIR) & ~w_conflict) | (r_state == ST_HOLD_B);
    assign w_pc_b  = r_buf_pc + 32'd4;

    assign w_in_ready = ~reset & ~bus.flush &
                        ((r_state == ST_EMPTY) | (bus.issue_ready & w_drain));
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_count_en = bus.issue_ready & ~bus.flush & (r_state != ST_EMPTY);

    assign bus.in_ready   = w_in_ready;
    assign bus.dual_cnt   = r_dual_cnt;
    assign bus.single_cnt = r_single_cnt;

    // Issue slots are a pure view of the buffer; EMPTY still drives buffer contents
    always_comb begin
        bus.issue0_valid = 1'b0;
        bus.issue0_instr = r_buf_a;
        bus.issue0_pc    = r_buf_pc;
        bus.issue1_valid = 1'b0;
        bus.issue1_instr = r_buf_b;
        bus.issue1_pc    = r_buf_pc;
        case (r_state)
            ST_PAIR: begin
                bus.issue0_valid = 1'b1;
                bus.issue1_valid = w_dual;
                bus.issue1_pc    = w_pc_b;
            end
            ST_HOLD_B: begin
                bus.issue0_valid = 1'b1;
                bus.issue0_instr = r_buf_b;
                bus.issue0_pc    = w_pc_b;
            end
            default: ;
        endcase
    end

    // Buffer and state: flush empties, an accepted pair reloads, a conflict leaves B behind
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_EMPTY;
            r_buf_a   <= '0;
            r_buf_b   <= '0;
            r_buf_b_v <= 1'b0;
            r_buf_pc  <= '0;
        end else if (bus.flush) begin
            r_state <= ST_EMPTY;
        end else if (w_accept) begin
            r_state   <= ST_PAIR;
            r_buf_a   <= bus.in_instr_a;
            r_buf_b   <= bus.in_instr_b;
            r_buf_b_v <= bus.in_b_valid;
            r_buf_pc  <= bus.in_pc;
        end else if (bus.issue_ready && r_state != ST_EMPTY) begin
            if (r_state == ST_PAIR && w_conflict)
                r_state <= ST_HOLD_B;
            else
                r_state <= ST_EMPTY;
        end
    end

    // Issue-event counters, one event per cycle the backend takes something
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dual_cnt   <= '0;
            r_single_cnt <= '0;
        end else if (w_count_en) begin
            if (w_dual)
                r_dual_cnt <= r_dual_cnt + 1'b1;
            else
                r_single_cnt <= r_single_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb/tb_dual_issue_scheduler.sv - directed checks of pairing, hazards, backpressure, flush and reset
module tb_dual_issue_scheduler;

    localparam logic [31:0] ADDI1 = 32'h00500093;
    localparam logic [31:0] ADDI3 = 32'h00700193;
    localparam logic [31:0] ADD2  = 32'h00108133;
    localparam logic [31:0] LW5   = 32'h0000A283;
    localparam logic [31:0] LW6   = 32'h00412303;
    localparam logic [31:0] JAL1  = 32'h000000EF;
    localparam logic [31:0] JAL0  = 32'h0000006F;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    dual_issue_scheduler_if #(.CNT_W(16)) bus ();

    dual_issue_scheduler #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic bv, input logic [31:0] pc);
        bus.in_valid   = 1'b1;
        bus.in_instr_a = a;
        bus.in_instr_b = b;
        bus.in_b_valid = bv;
        bus.in_pc      = pc;
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.in_b_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.issue_ready = 1'b1;
        bus.flush = 1'b0;
        bus.in_instr_a = '0;
        bus.in_instr_b = '0;
        bus.in_pc = '0;
        idle();
        #3;
        expect_eq("rst_in_ready", 32'(bus.in_ready), 0);
        expect_eq("rst_v0", 32'(bus.issue0_valid), 0);
        expect_eq("rst_v1", 32'(bus.issue1_valid), 0);
        expect_eq("rst_pc0", bus.issue0_pc, 0);
        expect_eq("rst_pc1", bus.issue1_pc, 0);
        expect_eq("rst_instr0", bus.issue0_instr, 0);
        expect_eq("rst_dual", 32'(bus.dual_cnt), 0);
        expect_eq("rst_single", 32'(bus.single_cnt), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;

        // Independent pair issues dual
        offer(ADDI1, ADDI3, 1'b1, 32'h100);
        #1 expect_eq("ind_in_ready", 32'(bus.in_ready), 1);
        tick(); idle(); #1;
        expect_eq("ind_v0", 32'(bus.issue0_valid), 1);
        expect_eq("ind_v1", 32'(bus.issue1_valid), 1);
        expect_eq("ind_pc0", bus.issue0_pc, 32'h100);
        expect_eq("ind_pc1", bus.issue1_pc, 32'h104);
        expect_eq("ind_i0", bus.issue0_instr, ADDI1);
        expect_eq("ind_i1", bus.issue1_instr, ADDI3);
        tick();
        expect_eq("ind_dual", 32'(bus.dual_cnt), 1);
        expect_eq("ind_empty", 32'(bus.issue0_valid), 0);

        // RAW pair splits
        offer(ADDI1, ADD2, 1'b1, 32'h200);
        tick(); idle(); #1;
        expect_eq("raw_v0", 32'(bus.issue0_valid), 1);
        expect_eq("raw_v1", 32'(bus.issue1_valid), 0);
        expect_eq("raw_i0", bus.issue0_instr, ADDI1);
        expect_eq("raw_rdy0", 32'(bus.in_ready), 0);
        tick();
        expect_eq("raw_b_i0", bus.issue0_instr, ADD2);
        expect_eq("raw_b_pc", bus.issue0_pc, 32'h204);
        expect_eq("raw_b_v1", 32'(bus.issue1_valid), 0);
        expect_eq("raw_rdy1", 32'(bus.in_ready), 1);
        tick();
        expect_eq("raw_single", 32'(bus.single_cnt), 2);
        expect_eq("raw_dual", 32'(bus.dual_cnt), 1);

        // Two loads share one memory port
        offer(LW5, LW6, 1'b1, 32'h300);
        tick(); idle(); #1;
        expect_eq("ld_rdy", 32'(bus.in_ready), 0);
        expect_eq("ld_v1", 32'(bus.issue1_valid), 0);
        expect_eq("ld_i0", bus.issue0_instr, LW5);
        tick();
        expect_eq("ld_b_i0", bus.issue0_instr, LW6);
        expect_eq("ld_b_pc", bus.issue0_pc, 32'h304);
        tick();
        expect_eq("ld_single", 32'(bus.single_cnt), 4);

        // Control op in A serializes; next pair accepted from HOLD_B is jal x0
        offer(JAL1, ADDI3, 1'b1, 32'h400);
        tick(); idle(); #1;
        expect_eq("jal_v1", 32'(bus.issue1_valid), 0);
        expect_eq("jal_i0", bus.issue0_instr, JAL1);
        tick();
        offer(JAL0, ADDI3, 1'b1, 32'h500);
        #1;
        expect_eq("jal_b_i0", bus.issue0_instr, ADDI3);
        expect_eq("jal_b_pc", bus.issue0_pc, 32'h404);
        expect_eq("jal_b_rdy", 32'(bus.in_ready), 1);
        tick(); idle(); #1;
        expect_eq("jal0_i0", bus.issue0_instr, JAL0);
        expect_eq("jal0_pc", bus.issue0_pc, 32'h500);
        expect_eq("jal0_v1", 32'(bus.issue1_valid), 0);
        expect_eq("jal0_single", 32'(bus.single_cnt), 6);

        // Backpressure holds everything
        bus.issue_ready = 1'b0;
        offer(ADDI1, ADDI3, 1'b1, 32'h700);
        for (int i = 0; i < 3; i++) begin
            #1;
            expect_eq("bp_rdy", 32'(bus.in_ready), 0);
            expect_eq("bp_v0", 32'(bus.issue0_valid), 1);
            expect_eq("bp_i0", bus.issue0_instr, JAL0);
            tick();
        end
        expect_eq("bp_single", 32'(bus.single_cnt), 6);
        expect_eq("bp_dual", 32'(bus.dual_cnt), 1);
        bus.issue_ready = 1'b1;
        idle();
        tick();
        expect_eq("bp_hold_i0", bus.issue0_instr, ADDI3);
        expect_eq("bp_hold_pc", bus.issue0_pc, 32'h504);
        expect_eq("bp_hold_single", 32'(bus.single_cnt), 7);

        // Flush in HOLD_B discards B and refuses the offered pair
        bus.flush = 1'b1;
        offer(ADDI1, ADDI3, 1'b1, 32'h800);
        #1;
        expect_eq("fl_rdy", 32'(bus.in_ready), 0);
        expect_eq("fl_v0_shown", 32'(bus.issue0_valid), 1);
        tick();
        bus.flush = 1'b0;
        idle();
        #1;
        expect_eq("fl_v0", 32'(bus.issue0_valid), 0);
        expect_eq("fl_v1", 32'(bus.issue1_valid), 0);
        expect_eq("fl_single", 32'(bus.single_cnt), 7);
        tick();
        expect_eq("fl_noaccept", 32'(bus.issue0_valid), 0);

        // Pair with slot B invalid issues A alone
        offer(ADDI1, ADDI3, 1'b0, 32'h900);
        tick(); idle(); #1;
        expect_eq("nob_v0", 32'(bus.issue0_valid), 1);
        expect_eq("nob_v1", 32'(bus.issue1_valid), 0);
        expect_eq("nob_rdy", 32'(bus.in_ready), 1);
        tick();
        expect_eq("nob_single", 32'(bus.single_cnt), 8);

        // Back-to-back independent pairs, one per cycle
        for (int i = 0; i < 3; i++) begin
            offer(ADDI1, ADDI3, 1'b1, 32'hA00 + 32'(8 * i));
            tick();
            expect_eq("tp_v1", 32'(bus.issue1_valid), 1);
            expect_eq("tp_pc1", bus.issue1_pc, 32'hA04 + 32'(8 * i));
            expect_eq("tp_rdy", 32'(bus.in_ready), 1);
        end
        idle();
        tick();
        expect_eq("tp_dual", 32'(bus.dual_cnt), 4);

        // Asynchronous reset mid-PAIR
        offer(ADDI1, ADDI3, 1'b1, 32'hB00);
        tick(); idle(); #1;
        expect_eq("ar_v0_pre", 32'(bus.issue0_valid), 1);
        #2 reset = 1'b1;
        #1;
        expect_eq("ar_v0", 32'(bus.issue0_valid), 0);
        expect_eq("ar_v1", 32'(bus.issue1_valid), 0);
        expect_eq("ar_i0", bus.issue0_instr, 0);
        expect_eq("ar_pc0", bus.issue0_pc, 0);
        expect_eq("ar_pc1", bus.issue1_pc, 0);
        expect_eq("ar_dual", 32'(bus.dual_cnt), 0);
        expect_eq("ar_single", 32'(bus.single_cnt), 0);
        expect_eq("ar_rdy", 32'(bus.in_ready), 0);
        tick();
        reset = 1'b0;
        tick();
        expect_eq("ar_after_v0", 32'(bus.issue0_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
